// File: rtl/trace_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trace_generator                                              |
// | Description : Random-walk trace pattern game round controller; optional    |
// |               snitch bonus cell enabled by TRACE_GENERATOR_SNITCH_EN.      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module trace_generator #(
    parameter int          PATH_LEN     = 4,
    parameter int          SHOW_CYCLES  = 50000000,
    parameter int          TRACE_CYCLES = 250000000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] already_traced,
    output logic [15:0] displayed_trace,
    output logic [15:0] snitch_location,
    output logic        reset_trace,
    output logic        busy,
    output logic        round_done,
    output logic [7:0]  score
);

    localparam logic [15:0] c_lfsr_seed  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [31:0] c_gen_last   = 32'(PATH_LEN - 1);
    localparam logic [31:0] c_show_last  = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] c_trace_last = 32'(TRACE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_TRACE = 3'd3,
        S_SCORE = 3'd4
    } state_t;

    state_t      r_state;
    logic [15:0] r_lfsr;
    logic [15:0] r_pattern;
    logic [3:0]  r_pos;
    logic [31:0] r_cnt;

    logic [15:0] w_lfsr_next;
    logic [3:0]  w_pos_next;
    logic [15:0] w_pattern_next;
    logic [15:0] w_snitch;
    logic [15:0] w_match;
    logic [4:0]  w_hits;
    logic [8:0]  w_sum;

    // Galois form, taps 16/14/13/11
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

    // One walk step per GEN cycle; the final step is folded in when the pattern is published
    always_comb begin
        w_pos_next     = r_pos;
        w_pattern_next = r_pattern;
        if (r_cnt == 32'd0) begin
            w_pos_next     = r_lfsr[3:0];
            w_pattern_next = 16'h0001 << r_lfsr[3:0];
        end else begin
            case (r_lfsr[1:0])
                2'd0:    if (r_pos[3:2] != 2'd0) w_pos_next = r_pos - 4'd4;
                2'd1:    if (r_pos[1:0] != 2'd3) w_pos_next = r_pos + 4'd1;
                2'd2:    if (r_pos[3:2] != 2'd3) w_pos_next = r_pos + 4'd4;
                default: if (r_pos[1:0] != 2'd0) w_pos_next = r_pos - 4'd1;
            endcase
            w_pattern_next = r_pattern | (16'h0001 << w_pos_next);
        end
    end

`ifdef TRACE_GENERATOR_SNITCH_EN
    logic [15:0] w_snitch_onehot;
    assign w_snitch_onehot = 16'h0001 << r_lfsr[7:4];
    assign w_snitch        = ((w_snitch_onehot & w_pattern_next) != 16'h0000) ? 16'h0000 : w_snitch_onehot;
`else
    assign w_snitch = 16'h0000;
`endif

    assign w_match = already_traced & displayed_trace;

    always_comb begin
        w_hits = 5'd0;
        for (int i = 0; i < 16; i++) begin
            w_hits = w_hits + {4'd0, w_match[i]};
        end
    end

`ifdef TRACE_GENERATOR_SNITCH_EN
    assign w_sum = {1'b0, score} + {4'd0, w_hits}
                 + ((already_traced == displayed_trace) ? 9'd4 : 9'd0)
                 + (((already_traced & snitch_location) != 16'h0000) ? 9'd10 : 9'd0);
`else
    assign w_sum = {1'b0, score} + {4'd0, w_hits}
                 + ((already_traced == displayed_trace) ? 9'd4 : 9'd0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_lfsr          <= c_lfsr_seed;
            r_cnt           <= 32'd0;
            r_pos           <= 4'd0;
            r_pattern       <= 16'h0000;
            displayed_trace <= 16'h0000;
            snitch_location <= 16'h0000;
            reset_trace     <= 1'b0;
            round_done      <= 1'b0;
            busy            <= 1'b0;
            score           <= 8'd0;
        end else begin
            r_lfsr      <= w_lfsr_next;
            reset_trace <= 1'b0;
            round_done  <= 1'b0;
            r_cnt       <= r_cnt + 32'd1;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 32'd0;
                    if (start) begin
                        r_state   <= S_GEN;
                        r_pattern <= 16'h0000;
                        busy      <= 1'b1;
                    end
                end
                S_GEN: begin
                    r_pos     <= w_pos_next;
                    r_pattern <= w_pattern_next;
                    if (r_cnt == c_gen_last) begin
                        r_state         <= S_SHOW;
                        r_cnt           <= 32'd0;
                        displayed_trace <= w_pattern_next;
                        snitch_location <= w_snitch;
                        reset_trace     <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == c_show_last) begin
                        r_state <= S_TRACE;
                        r_cnt   <= 32'd0;
                    end
                end
                S_TRACE: begin
                    if (r_cnt == c_trace_last) begin
                        r_state    <= S_SCORE;
                        r_cnt      <= 32'd0;
                        round_done <= 1'b1;
                    end
                end
                S_SCORE: begin
                    score           <= (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
                    r_state         <= S_IDLE;
                    r_cnt           <= 32'd0;
                    busy            <= 1'b0;
                    displayed_trace <= 16'h0000;
                    snitch_location <= 16'h0000;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 32'd0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_generator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trace_generator                                           |
// | Description : Scoreboard bench for trace_generator (short phase lengths).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_trace_generator;

    localparam int PATH_LEN     = 4;
    localparam int SHOW_CYCLES  = 5;
    localparam int TRACE_CYCLES = 8;

    logic        clk            = 1'b0;
    logic        reset_n        = 1'b0;
    logic        start          = 1'b0;
    logic [15:0] already_traced = 16'h0000;
    logic [15:0] displayed_trace;
    logic [15:0] snitch_location;
    logic        reset_trace;
    logic        busy;
    logic        round_done;
    logic [7:0]  score;

    int total = 0;
    int bad   = 0;
    int exp_score = 0;
    logic [15:0] m_lfsr;
    logic [15:0] pat_q[$];
    logic [15:0] snitch_q[$];
    int          score_q[$];
    bit          score_pending = 1'b0;
    int          score_next = 0;

    always #5 clk = ~clk;

    trace_generator #(
        .PATH_LEN    (PATH_LEN),
        .SHOW_CYCLES (SHOW_CYCLES),
        .TRACE_CYCLES(TRACE_CYCLES),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .already_traced (already_traced),
        .displayed_trace(displayed_trace),
        .snitch_location(snitch_location),
        .reset_trace    (reset_trace),
        .busy           (busy),
        .round_done     (round_done),
        .score          (score)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) begin
            n[15] = ~n[15];
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    always @(posedge clk) m_lfsr <= !reset_n ? 16'hACE1 : lfsr_step(m_lfsr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT publishes a pattern or finishes a round
    always @(negedge clk) begin
        if (!reset_n) begin
            score_pending = 1'b0;
        end else begin
            if (score_pending) begin
                check("score", 32'(score), 32'(score_next));
                score_pending = 1'b0;
            end
            if (reset_trace) begin
                if (pat_q.size() == 0) begin
                    check("reset_trace_unexpected", 32'(reset_trace), 32'd0);
                end else begin
                    check("pattern", 32'(displayed_trace), 32'(pat_q.pop_front()));
                    check("snitch", 32'(snitch_location), 32'(snitch_q.pop_front()));
                end
            end
            if (round_done) begin
                if (score_q.size() == 0) begin
                    check("round_done_unexpected", 32'(round_done), 32'd0);
                end else begin
                    score_next    = score_q.pop_front();
                    score_pending = 1'b1;
                end
            end
        end
    end

    // mode: 0 trace nothing, 1 trace whole pattern, 2 trace snitch only, 3 trace lowest cell
    task automatic run_round(input int mode, input bit keep_start, input bit pulse_show, input bit abort);
        logic [15:0] pat, snt, at;
        int row, col, add, last;
        bit busy_ok, rt_ok, rd_ok, idle_ok;
        busy_ok = 1'b1; rt_ok = 1'b1; rd_ok = 1'b1; idle_ok = 1'b1;
        pat = 16'h0000; snt = 16'h0000; at = 16'h0000; row = 0; col = 0;
        last = abort ? 11 : 17;
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        for (int off = 0; off <= last; off++) begin
            if (off > 0) begin
                @(posedge clk); #1;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (reset_trace !== (off == 4)) rt_ok = 1'b0;
            if (round_done !== (off == 17)) rd_ok = 1'b0;
            if (off == 0) begin
                row = int'(m_lfsr[3:2]);
                col = int'(m_lfsr[1:0]);
                pat[row*4+col] = 1'b1;
            end else if (off < PATH_LEN) begin
                case (m_lfsr[1:0])
                    2'd0:    if (row > 0) row--;
                    2'd1:    if (col < 3) col++;
                    2'd2:    if (row < 3) row++;
                    default: if (col > 0) col--;
                endcase
                pat[row*4+col] = 1'b1;
            end
            if (off == PATH_LEN - 1) begin
`ifdef TRACE_GENERATOR_SNITCH_EN
                if (!pat[m_lfsr[7:4]]) snt[m_lfsr[7:4]] = 1'b1;
`endif
                pat_q.push_back(pat);
                snitch_q.push_back(snt);
            end
            if (off == 4) begin
                case (mode)
                    0:       at = 16'h0000;
                    1:       at = pat;
                    2:       at = snt;
                    default: at = pat & (~pat + 16'd1);
                endcase
                already_traced = at;
                if (!abort) begin
                    add = $countones(at & pat) + ((at == pat) ? 4 : 0) + (((at & snt) != 16'h0000) ? 10 : 0);
                    exp_score = (exp_score + add > 255) ? 255 : exp_score + add;
                    score_q.push_back(exp_score);
                end
            end
            if (pulse_show && !keep_start) begin
                if (off == 5) start = 1'b1;
                if (off == 6) start = 1'b0;
            end
        end
        check("busy_during_round", 32'(busy_ok), 32'd1);
        check("reset_trace_timing", 32'(rt_ok), 32'd1);
        check("round_done_timing", 32'(rd_ok), 32'd1);
        if (abort) begin
            reset_n = 1'b0;
            @(posedge clk); #1;
            check("abort_busy_next", 32'(busy), 32'd0);
            repeat (2) begin
                @(posedge clk); #1;
            end
            exp_score = 0;
            check("abort_displayed", 32'(displayed_trace), 32'd0);
            check("abort_snitch", 32'(snitch_location), 32'd0);
            check("abort_reset_trace", 32'(reset_trace), 32'd0);
            check("abort_round_done", 32'(round_done), 32'd0);
            check("abort_score", 32'(score), 32'd0);
            reset_n = 1'b1;
            repeat (10) begin
                @(posedge clk); #1;
                if (busy !== 1'b0 || round_done !== 1'b0) idle_ok = 1'b0;
            end
            check("idle_after_reset", 32'(idle_ok), 32'd1);
        end else begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_displayed", 32'(displayed_trace), 32'd0);
            check("idle_snitch", 32'(snitch_location), 32'd0);
        end
        already_traced = 16'h0000;
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_displayed", 32'(displayed_trace), 32'd0);
        check("rst_snitch", 32'(snitch_location), 32'd0);
        check("rst_reset_trace", 32'(reset_trace), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_round_done", 32'(round_done), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("idle_without_start", 32'(busy), 32'd0);

        run_round(1, 1'b0, 1'b0, 1'b0);
        run_round(0, 1'b0, 1'b0, 1'b0);
        run_round(3, 1'b0, 1'b1, 1'b0);
        run_round(2, 1'b0, 1'b0, 1'b0);
        run_round(1, 1'b1, 1'b0, 1'b0);
        run_round(3, 1'b1, 1'b0, 1'b0);
        run_round(0, 1'b0, 1'b0, 1'b0);
        run_round(1, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 80 && exp_score <= 250; n++) run_round(1, 1'b0, 1'b0, 1'b0);
        run_round(1, 1'b0, 1'b0, 1'b0);
        run_round(1, 1'b0, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("score_saturated", 32'(score), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
